// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared widths, reset PC and state encodings for the fetch sequencer.
// Optional trap redirect is enabled with FETCH_TRAP_EN.
`default_nettype none

package fetch_ctrl_pkg;

  localparam int          REG_W    = 64;
  localparam int          INST_W   = 32;
  localparam logic [63:0] PC_START = 64'h0000_0000_8000_0000;
  localparam logic [63:0] PC_STEP  = 64'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_redirect_sel.sv
// fetch_redirect_sel: merges redirect strobes into one redir/target pair.
// With FETCH_TRAP_EN, a trap takes priority over a branch/jump.
`default_nettype none

module fetch_redirect_sel
  import fetch_ctrl_pkg::*;
(
  input  logic             bj_ena,
  input  logic [REG_W-1:0] bj_target,
`ifdef FETCH_TRAP_EN
  input  logic             trap_ena,
  input  logic [REG_W-1:0] trap_target,
`endif
  output logic             redir,
  output logic [REG_W-1:0] target
);

`ifdef FETCH_TRAP_EN
  assign redir  = trap_ena | bj_ena;
  assign target = trap_ena ? trap_target : bj_target;
`else
  assign redir  = bj_ena;
  assign target = bj_target;
`endif

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and single-outstanding instruction fetch sequencer with a decode slot.
// Build option FETCH_TRAP_EN adds the trap redirect ports.
`default_nettype none

module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              bj_ena,
  input  logic [REG_W-1:0]  bj_target,
`ifdef FETCH_TRAP_EN
  input  logic              trap_ena,
  input  logic [REG_W-1:0]  trap_target,
`endif
  output logic              if_req,
  output logic [REG_W-1:0]  if_addr,
  input  logic              if_ready,
  input  logic              if_rvalid,
  input  logic [INST_W-1:0] if_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [REG_W-1:0]  inst_pc,
  input  logic              id_ready
);

  fetch_state_t     state;
  logic [REG_W-1:0] pc;
  logic             redir;
  logic [REG_W-1:0] target;

  fetch_redirect_sel u_redirect_sel (
    .bj_ena      (bj_ena),
    .bj_target   (bj_target),
`ifdef FETCH_TRAP_EN
    .trap_ena    (trap_ena),
    .trap_target (trap_target),
`endif
    .redir       (redir),
    .target      (target)
  );

  // Request side depends only on state and pc, never on same-cycle inputs.
  assign if_req  = (state == S_REQ);
  assign if_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= PC_START;
      state      <= S_REQ;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (redir) begin
            pc <= target;
            // An accepted request used the old address; its response must be dropped.
            state <= if_ready ? S_DROP : S_REQ;
          end else if (if_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (if_rvalid) begin
            if (redir) begin
              pc    <= target;
              state <= S_REQ;
            end else begin
              inst       <= if_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= pc + PC_STEP;
              state      <= S_HOLD;
            end
          end else if (redir) begin
            pc    <= target;
            state <= S_DROP;
          end
        end
        S_DROP: begin
          if (redir) pc <= target;
          if (if_rvalid) state <= S_REQ;
        end
        S_HOLD: begin
          if (redir) begin
            inst_valid <= 1'b0;
            pc         <= target;
            state      <= S_REQ;
          end else if (id_ready) begin
            inst_valid <= 1'b0;
            state      <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
// Trap-priority vector is exercised only when FETCH_TRAP_EN is defined.
`default_nettype none

module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              bj_ena;
  logic [REG_W-1:0]  bj_target;
`ifdef FETCH_TRAP_EN
  logic              trap_ena;
  logic [REG_W-1:0]  trap_target;
`endif
  logic              if_req;
  logic [REG_W-1:0]  if_addr;
  logic              if_ready;
  logic              if_rvalid;
  logic [INST_W-1:0] if_rdata;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [REG_W-1:0]  inst_pc;
  logic              id_ready;

  int n_cmp = 0;
  int n_err = 0;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bj_ena      (bj_ena),
    .bj_target   (bj_target),
`ifdef FETCH_TRAP_EN
    .trap_ena    (trap_ena),
    .trap_target (trap_target),
`endif
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_ready    (if_ready),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .id_ready    (id_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From REQ: accept the request, return data the next cycle; ends in HOLD.
  task automatic fetch_one(input logic [31:0] d);
    if_ready = 1'b1;
    tick();
    if_ready  = 1'b0;
    if_rvalid = 1'b1;
    if_rdata  = d;
    tick();
    if_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; bj_ena = 1'b0; bj_target = '0;
`ifdef FETCH_TRAP_EN
    trap_ena = 1'b0; trap_target = '0;
`endif
    if_ready = 1'b0; if_rvalid = 1'b0; if_rdata = '0; id_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_req",   {63'd0, if_req}, 64'd1);
    check("rst_addr",  if_addr, 64'h8000_0000);
    check("rst_valid", {63'd0, inst_valid}, 64'd0);
    check("rst_inst",  {32'd0, inst}, 64'd0);
    check("rst_ipc",   inst_pc, 64'd0);
    tick();
    check("rst_req_after", {63'd0, if_req}, 64'd1);

    // Back-to-back fetches, id_ready high: 3 cycles each.
    fetch_one(32'h0000_0013);
    check("f0_valid", {63'd0, inst_valid}, 64'd1);
    check("f0_inst",  {32'd0, inst}, 64'h13);
    check("f0_ipc",   inst_pc, 64'h8000_0000);
    tick();
    check("f1_req",   {63'd0, if_req}, 64'd1);
    check("f1_addr",  if_addr, 64'h8000_0004);
    check("f1_clr",   {63'd0, inst_valid}, 64'd0);
    fetch_one(32'h0000_1111);
    check("f1_ipc",   inst_pc, 64'h8000_0004);
    tick();
    check("f2_addr",  if_addr, 64'h8000_0008);

    // Decode stall in HOLD.
    id_ready = 1'b0;
    fetch_one(32'h0000_2222);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {63'd0, inst_valid}, 64'd1);
      check("stall_inst",  {32'd0, inst}, 64'h2222);
      check("stall_ipc",   inst_pc, 64'h8000_0008);
      check("stall_req",   {63'd0, if_req}, 64'd0);
    end
    id_ready = 1'b1;
    tick();
    check("unstall_valid", {63'd0, inst_valid}, 64'd0);
    check("unstall_req",   {63'd0, if_req}, 64'd1);
    check("unstall_addr",  if_addr, 64'h8000_000C);

    // Branch while waiting; response arrives two cycles later and is dropped.
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0; bj_ena = 1'b1; bj_target = 64'h8000_0100;
    tick();
    bj_ena = 1'b0;
    tick();
    check("wait_bj_req", {63'd0, if_req}, 64'd0);
    if_rvalid = 1'b1; if_rdata = 32'hDEAD_BEEF;
    tick();
    if_rvalid = 1'b0;
    check("wait_bj_valid", {63'd0, inst_valid}, 64'd0);
    check("wait_bj_req2",  {63'd0, if_req}, 64'd1);
    check("wait_bj_addr",  if_addr, 64'h8000_0100);

    // Branch in the same cycle the request is accepted.
    if_ready = 1'b1; bj_ena = 1'b1; bj_target = 64'h8000_0300;
    tick();
    if_ready = 1'b0; bj_ena = 1'b0;
    check("acc_bj_req",  {63'd0, if_req}, 64'd0);
    if_rvalid = 1'b1; if_rdata = 32'hBAD0_0001;
    tick();
    if_rvalid = 1'b0;
    check("acc_bj_valid", {63'd0, inst_valid}, 64'd0);
    check("acc_bj_addr",  if_addr, 64'h8000_0300);
    check("acc_bj_req2",  {63'd0, if_req}, 64'd1);

    // Branch in REQ without acceptance.
    bj_ena = 1'b1; bj_target = 64'h8000_0400;
    tick();
    bj_ena = 1'b0;
    check("req_bj_req",  {63'd0, if_req}, 64'd1);
    check("req_bj_addr", if_addr, 64'h8000_0400);

    // Response and branch in the same WAIT cycle.
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0; if_rvalid = 1'b1; if_rdata = 32'hBAD0_0002;
    bj_ena = 1'b1; bj_target = 64'h8000_0500;
    tick();
    if_rvalid = 1'b0; bj_ena = 1'b0;
    check("rv_bj_valid", {63'd0, inst_valid}, 64'd0);
    check("rv_bj_req",   {63'd0, if_req}, 64'd1);
    check("rv_bj_addr",  if_addr, 64'h8000_0500);

    // Branch in HOLD flushes the slot even with id_ready high.
    fetch_one(32'h0000_3333);
    check("hold_ipc", inst_pc, 64'h8000_0500);
    bj_ena = 1'b1; bj_target = 64'h8000_0600;
    tick();
    bj_ena = 1'b0;
    check("hold_bj_valid", {63'd0, inst_valid}, 64'd0);
    check("hold_bj_addr",  if_addr, 64'h8000_0600);

`ifdef FETCH_TRAP_EN
    fetch_one(32'h0000_4444);
    trap_ena = 1'b1; trap_target = 64'h8000_0200;
    bj_ena = 1'b1; bj_target = 64'h8000_0100;
    tick();
    trap_ena = 1'b0; bj_ena = 1'b0;
    check("trap_valid", {63'd0, inst_valid}, 64'd0);
    check("trap_addr",  if_addr, 64'h8000_0200);
`endif

    // PC wrap-around.
    bj_ena = 1'b1; bj_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    bj_ena = 1'b0;
    check("wrap_addr0", if_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch_one(32'h0000_5555);
    check("wrap_ipc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap_addr1", if_addr, 64'h0);

    // Reset mid-transaction.
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_req",   {63'd0, if_req}, 64'd1);
    check("mid_rst_addr",  if_addr, 64'h8000_0000);
    check("mid_rst_valid", {63'd0, inst_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
